// File: rtl/rst_seq_gen.sv
// rst_seq_gen: synchronised reset hold followed by staggered, maskable per-channel reset release.
module rst_seq_gen #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGGER     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sw_rst_req,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  ch_rstn_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_cnt
);
  localparam int MAXC = HOLD_CYCLES > STAGGER ? HOLD_CYCLES : STAGGER;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;
  state_t           state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic             rst_sync;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [N_CH-1:0]  ch_n, sel;
  logic [CNT_W-1:0] seq_n;
  logic             busy_n, done_n;
  assign rst_sync = sync[SYNC_STAGES-1];
  assign sel      = N_CH'(1) << idx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  // Synchronous clear while the synchroniser output is low keeps every register at its reset value.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    ch_n    = ch_rstn_o;
    seq_n   = seq_cnt;
    if (!rst_sync) begin
      state_n = HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      ch_n    = '0;
      seq_n   = '0;
    end else if (sw_rst_req) begin
      state_n = HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      ch_n    = '0;
    end else if (state == HOLD) begin
      state_n = cnt == CW'(HOLD_CYCLES - 1) ? RELEASE : HOLD;
      cnt_n   = cnt == CW'(HOLD_CYCLES - 1) ? '0 : cnt + CW'(1);
    end else if (state == RELEASE) begin
      ch_n = cnt == '0 ? (ch_rstn_o & ~sel) | (ch_en & sel) : ch_rstn_o;
      if (cnt == CW'(STAGGER - 1)) begin
        if (idx == IW'(N_CH - 1)) begin
          state_n = DONE;
          seq_n   = seq_cnt + CNT_W'(seq_cnt != '1);
        end else begin
          idx_n = idx + IW'(1);
          cnt_n = '0;
        end
      end else cnt_n = cnt + CW'(1);
    end
    busy_n = rst_sync && state_n != DONE;
    done_n = rst_sync && state_n == DONE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      ch_rstn_o <= '0;
      seq_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      ch_rstn_o <= ch_n;
      seq_cnt   <= seq_n;
      busy      <= busy_n;
      done      <= done_n;
    end
endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: directed checks of the reset sequencer, default and minimal configurations.
module tb_rst_seq_gen;
  logic        clk = 1'b0;
  logic        rstn, sw, rstn_b, sw_b, ch_en_b;
  logic [3:0]  ch_en, ch;
  logic        busy, done, ch_b, busy_b, done_b;
  logic [15:0] seq;
  logic [1:0]  seq_b;
  int          checks = 0, errors = 0, cur = 0;

  always #5 clk = ~clk;

  rst_seq_gen dut_a (
    .clk(clk), .rstn(rstn), .sw_rst_req(sw), .ch_en(ch_en),
    .ch_rstn_o(ch), .busy(busy), .done(done), .seq_cnt(seq)
  );
  rst_seq_gen #(.N_CH(1), .HOLD_CYCLES(1), .STAGGER(1), .SYNC_STAGES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rstn(rstn_b), .sw_rst_req(sw_b), .ch_en(ch_en_b),
    .ch_rstn_o(ch_b), .busy(busy_b), .done(done_b), .seq_cnt(seq_b)
  );

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    cur += n;
    #1;
  endtask

  task automatic adv_to(input int n);
    adv(n - cur);
  endtask

  task automatic pulse();
    sw = 1'b1;
    adv(1);
    sw = 1'b0;
    cur = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rstn_b = 1'b0; sw = 1'b0; sw_b = 1'b0; ch_en = 4'hf; ch_en_b = 1'b1;
    #1;
    checks++; if ({ch, busy, done, seq} !== 22'd0) begin errors++; $display("FAIL reset_a got=%h exp=0", {ch, busy, done, seq}); end
    checks++; if ({ch_b, busy_b, done_b, seq_b} !== 5'd0) begin errors++; $display("FAIL reset_b got=%h exp=0", {ch_b, busy_b, done_b, seq_b}); end
    adv(3);
    checks++; if ({ch, busy, done, seq} !== 22'd0) begin errors++; $display("FAIL reset_held got=%h exp=0", {ch, busy, done, seq}); end
  endtask

  task automatic test_power_on();
    int         tt[8] = '{2, 3, 12, 13, 17, 21, 25, 28};
    logic [5:0] oo[8] = '{6'b000000, 6'b000010, 6'b000010, 6'b000110, 6'b001110, 6'b011110, 6'b111110, 6'b111101};
    @(negedge clk) rstn = 1'b1;
    cur = 0;
    foreach (tt[i]) begin
      adv_to(tt[i]);
      checks++; if ({ch, busy, done} !== oo[i]) begin errors++; $display("FAIL power_on e%0d out=%b exp=%b", tt[i], {ch, busy, done}, oo[i]); end
    end
    checks++; if (seq !== 16'd1) begin errors++; $display("FAIL power_on seq got=%0d exp=1", seq); end
  endtask

  task automatic test_sw_in_done();
    int         tt[4] = '{10, 11, 25, 26};
    logic [5:0] oo[4] = '{6'b000010, 6'b000110, 6'b111110, 6'b111101};
    adv_to(39);
    pulse();
    checks++; if ({ch, busy, done, seq} !== {6'b000010, 16'd1}) begin errors++; $display("FAIL sw_done e40 got=%h exp=%h", {ch, busy, done, seq}, {6'b000010, 16'd1}); end
    foreach (tt[i]) begin
      adv_to(tt[i]);
      checks++; if ({ch, busy, done} !== oo[i]) begin errors++; $display("FAIL sw_done t%0d out=%b exp=%b", tt[i], {ch, busy, done}, oo[i]); end
    end
    checks++; if (seq !== 16'd2) begin errors++; $display("FAIL sw_done seq got=%0d exp=2", seq); end
  endtask

  task automatic test_mask();
    int         tt[5] = '{11, 15, 19, 23, 26};
    logic [5:0] oo[5] = '{6'b000110, 6'b001110, 6'b001110, 6'b101110, 6'b101101};
    ch_en = 4'b1011;
    adv(2);
    checks++; if ({ch, busy, done} !== 6'b111101) begin errors++; $display("FAIL mask idle out=%b exp=111101", {ch, busy, done}); end
    pulse();
    foreach (tt[i]) begin
      adv_to(tt[i]);
      if (tt[i] == 15) ch_en = 4'b1000;
      checks++; if ({ch, busy, done} !== oo[i]) begin errors++; $display("FAIL mask t%0d out=%b exp=%b", tt[i], {ch, busy, done}, oo[i]); end
    end
    checks++; if (seq !== 16'd3) begin errors++; $display("FAIL mask seq got=%0d exp=3", seq); end
  endtask

  task automatic test_sw_in_release();
    ch_en = 4'hf;
    pulse();
    adv_to(15);
    checks++; if ({ch, busy, done} !== 6'b001110) begin errors++; $display("FAIL sw_rel t15 out=%b exp=001110", {ch, busy, done}); end
    pulse();
    checks++; if ({ch, busy, done, seq} !== {6'b000010, 16'd3}) begin errors++; $display("FAIL sw_rel restart got=%h exp=%h", {ch, busy, done, seq}, {6'b000010, 16'd3}); end
    adv_to(11);
    checks++; if ({ch, busy, done} !== 6'b000110) begin errors++; $display("FAIL sw_rel t11 out=%b exp=000110", {ch, busy, done}); end
    adv_to(26);
    checks++; if ({ch, busy, done, seq} !== {6'b111101, 16'd4}) begin errors++; $display("FAIL sw_rel done got=%h exp=%h", {ch, busy, done, seq}, {6'b111101, 16'd4}); end
  endtask

  task automatic test_sw_at_done();
    pulse();
    adv_to(25);
    checks++; if ({ch, busy, done} !== 6'b111110) begin errors++; $display("FAIL sw_at_done t25 out=%b exp=111110", {ch, busy, done}); end
    pulse();
    checks++; if ({ch, busy, done, seq} !== {6'b000010, 16'd4}) begin errors++; $display("FAIL sw_at_done restart got=%h exp=%h", {ch, busy, done, seq}, {6'b000010, 16'd4}); end
    adv_to(26);
    checks++; if ({ch, busy, done, seq} !== {6'b111101, 16'd5}) begin errors++; $display("FAIL sw_at_done done got=%h exp=%h", {ch, busy, done, seq}, {6'b111101, 16'd5}); end
  endtask

  task automatic test_sw_held();
    sw = 1'b1;
    adv(3);
    sw = 1'b0;
    cur = 0;
    checks++; if ({ch, busy, done} !== 6'b000010) begin errors++; $display("FAIL sw_held t0 out=%b exp=000010", {ch, busy, done}); end
    adv_to(10);
    checks++; if ({ch, busy, done} !== 6'b000010) begin errors++; $display("FAIL sw_held t10 out=%b exp=000010", {ch, busy, done}); end
    adv_to(11);
    checks++; if ({ch, busy, done} !== 6'b000110) begin errors++; $display("FAIL sw_held t11 out=%b exp=000110", {ch, busy, done}); end
    adv_to(26);
    checks++; if ({ch, busy, done, seq} !== {6'b111101, 16'd6}) begin errors++; $display("FAIL sw_held done got=%h exp=%h", {ch, busy, done, seq}, {6'b111101, 16'd6}); end
  endtask

  task automatic test_async_reset();
    int         tt[5] = '{2, 3, 12, 13, 28};
    logic [5:0] oo[5] = '{6'b000000, 6'b000010, 6'b000010, 6'b000110, 6'b111101};
    pulse();
    adv_to(13);
    checks++; if ({ch, busy, done} !== 6'b000110) begin errors++; $display("FAIL async t13 out=%b exp=000110", {ch, busy, done}); end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({ch, busy, done, seq} !== 22'd0) begin errors++; $display("FAIL async low got=%h exp=0", {ch, busy, done, seq}); end
    #2 rstn = 1'b1;
    cur = 0;
    foreach (tt[i]) begin
      adv_to(tt[i]);
      checks++; if ({ch, busy, done} !== oo[i]) begin errors++; $display("FAIL async e%0d out=%b exp=%b", tt[i], {ch, busy, done}, oo[i]); end
    end
    checks++; if (seq !== 16'd1) begin errors++; $display("FAIL async seq got=%0d exp=1", seq); end
  endtask

  task automatic test_boundary();
    logic [1:0] exp_seq;
    rstn_b = 1'b1;
    cur = 0;
    adv_to(2);
    checks++; if ({ch_b, busy_b, done_b} !== 3'b000) begin errors++; $display("FAIL bnd e2 out=%b exp=000", {ch_b, busy_b, done_b}); end
    adv_to(3);
    checks++; if ({ch_b, busy_b, done_b} !== 3'b010) begin errors++; $display("FAIL bnd t1 out=%b exp=010", {ch_b, busy_b, done_b}); end
    adv_to(4);
    checks++; if ({ch_b, busy_b, done_b, seq_b} !== 5'b10101) begin errors++; $display("FAIL bnd t2 got=%b exp=10101", {ch_b, busy_b, done_b, seq_b}); end
    for (int k = 2; k <= 6; k++) begin
      exp_seq = k > 3 ? 2'd3 : 2'(k);
      sw_b = 1'b1;
      adv(1);
      sw_b = 1'b0;
      checks++; if ({ch_b, busy_b, done_b} !== 3'b010) begin errors++; $display("FAIL bnd restart%0d out=%b exp=010", k, {ch_b, busy_b, done_b}); end
      adv(2);
      checks++; if ({ch_b, busy_b, done_b, seq_b} !== {3'b101, exp_seq}) begin errors++; $display("FAIL bnd seq%0d got=%b exp=%b", k, {ch_b, busy_b, done_b, seq_b}, {3'b101, exp_seq}); end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_in_done();
    test_mask();
    test_sw_in_release();
    test_sw_at_done();
    test_sw_held();
    test_async_reset();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Synthesisable, parametrised reset sequencer; generalises the bench-level "hold reset N cycles, then release" into a reusable block.
- Synchronises the board-level asynchronous reset, holds it for a programmable number of cycles, then releases N_CH downstream reset channels one at a time with a fixed stagger.
- Supports per-channel masking, software-requested re-sequencing, and status outputs.
- Sits at the top of each subsystem in front of all channel-level reset inputs.

Parameters:
- N_CH, 4, number of reset output channels (>=1)
- HOLD_CYCLES, 10, cycles held in reset after synchronised release (>=1)
- STAGGER, 4, cycles between successive channel releases (>=1)
- SYNC_STAGES, 2, reset synchroniser depth (>=2)
- CNT_W, 16, width of completed-sequence counter

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised internally
- sw_rst_req  input  1  single-cycle request to re-run the sequence
- ch_en  input  N_CH  per-channel enable; a masked channel is never released
- ch_rstn_o  output  N_CH  active-low channel resets
- busy  output  1  sequence in progress (HOLD or RELEASE)
- done  output  1  all channels processed, sequence idle
- seq_cnt  output  CNT_W  completed sequences, saturating

Behaviour:
- Reset values (rstn=0): ch_rstn_o=0, busy=0, done=0, seq_cnt=0, state=HOLD, cnt=0, idx=0, synchroniser chain all 0. All of these registers reset asynchronously.
- Synchroniser:
  - SYNC_STAGES-flop chain with D=1; rst_sync is the last flop.
  - rst_sync goes 1 SYNC_STAGES edges after rstn deasserts.
  - rst_sync goes 0 immediately (asynchronously) on rstn=0.
- FSM states are HOLD, RELEASE and DONE. All FSM registers and outputs are held at reset values while rst_sync=0.
- Timing reference: t=1 is the first rising edge that samples rst_sync=1.
- HOLD:
  - busy=1.
  - On each edge: if cnt==HOLD_CYCLES-1, go to RELEASE with cnt=0; otherwise cnt++.
  - HOLD therefore ends at edge t=HOLD_CYCLES.
- RELEASE:
  - busy=1.
  - On the edge with cnt==0: ch_rstn_o[idx] <= ch_en[idx]. ch_en is sampled only at this edge.
  - On the edge with cnt==STAGGER-1: if idx==N_CH-1, go to DONE; otherwise idx++ and cnt=0.
  - Otherwise cnt++.
  - When STAGGER=1, both actions happen on the same edge.
  - Channel k is released at edge t=HOLD_CYCLES+1+k*STAGGER.
  - DONE is entered at edge t=HOLD_CYCLES+N_CH*STAGGER.
- DONE:
  - busy=0, done=1; ch_rstn_o is stable.
  - seq_cnt increments by 1 on the RELEASE->DONE transition, saturating at 2^CNT_W-1.
- sw_rst_req=1 sampled in any state while rst_sync=1, on the next edge:
  - ch_rstn_o=0, done=0, busy=1;
  - state=HOLD, cnt=0, idx=0;
  - the full sequence re-runs with the same timing; that edge counts as t=0.
- sw_rst_req held high for several cycles keeps the block restarting, so HOLD begins after the last high cycle.
- sw_rst_req on the edge that would enter DONE: the restart wins and seq_cnt does not increment.
- rstn=0 at any time: immediate return to reset values. seq_cnt is cleared; sw_rst_req is ignored.
- ch_en changes after a channel's release edge have no effect until the next sequence.
- busy and done are never both 1. A registered output never changes between clock edges except on asynchronous reset.

Test Plan:
- Defaults, rstn released before edge e1: rst_sync=1 after e2; ch_rstn_o bit0 goes high at e13, bit1 at e17, bit2 at e21, bit3 at e25. done=1 and seq_cnt=1 at e28; busy=1 from e3 to e28.
- ch_en=4'b1011: same timing as above, but ch_rstn_o[2] stays 0. Final ch_rstn_o=4'b1011, done=1.
- sw_rst_req pulse in DONE at edge e40: ch_rstn_o=0 and busy=1 at e40. bit0 high at e51, done at e66, seq_cnt=2.
- sw_rst_req during RELEASE, right after bit1 is released: all outputs drop to 0 on the next edge, the sequence restarts from HOLD, and seq_cnt is unchanged until the new DONE.
- rstn pulsed low for 3 ns mid-RELEASE, between edges: ch_rstn_o, busy and seq_cnt go to 0 without waiting for a clock edge. After release, the full power-on timing repeats from a new e1.
- Boundary config N_CH=1, HOLD_CYCLES=1, STAGGER=1, CNT_W=2: ch_rstn_o=1 at t=2 and done at t=2. After 5 sw_rst_req-driven sequences, seq_cnt saturates at 3.
